// File: rtl/fpu_issuer_if.sv
// Bundles the core request/response channels and the FPU command port of the issuer.
interface fpu_issuer_if;
    localparam int unsigned OP_W   = 6;
    localparam int unsigned REG_W  = 5;
    localparam int unsigned DATA_W = 32;

    logic              req_valid;
    logic              req_ready;
    logic [OP_W-1:0]   req_op;
    logic [REG_W-1:0]  req_x1;
    logic [REG_W-1:0]  req_x2;
    logic [REG_W-1:0]  req_y;
    logic [DATA_W-1:0] req_data;

    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_data;
    logic              resp_cond;
    logic              resp_err;
    logic              busy;

    logic [REG_W-1:0]  fpu_x1;
    logic [REG_W-1:0]  fpu_x2;
    logic [REG_W-1:0]  fpu_y;
    logic [OP_W-1:0]   fpu_operation;
    logic [DATA_W-1:0] fpu_in_data;
    logic              fpu_ready;
    logic              fpu_valid;
    logic              fpu_cond;
    logic [DATA_W-1:0] fpu_out_data;

    // Issuer view: serves the core, drives the FPU.
    modport master (
        input  req_valid, req_op, req_x1, req_x2, req_y, req_data, resp_ready,
               fpu_valid, fpu_cond, fpu_out_data,
        output req_ready, resp_valid, resp_data, resp_cond, resp_err, busy,
               fpu_x1, fpu_x2, fpu_y, fpu_operation, fpu_in_data, fpu_ready
    );

    // Environment view: the core and the FPU together.
    modport slave (
        output req_valid, req_op, req_x1, req_x2, req_y, req_data, resp_ready,
               fpu_valid, fpu_cond, fpu_out_data,
        input  req_ready, resp_valid, resp_data, resp_cond, resp_err, busy,
               fpu_x1, fpu_x2, fpu_y, fpu_operation, fpu_in_data, fpu_ready
    );
endinterface

// File: rtl/fpu_issuer.sv
// Core-side FPU command initiator: one request in, FPU handshake plus optional
// drain cycle, exactly one response out.
module fpu_issuer #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 8
) (
    input  logic         clk,
    input  logic         rstn,
    fpu_issuer_if.master bus
);
    localparam int unsigned OP_W   = 6;
    localparam int unsigned REG_W  = 5;
    localparam int unsigned DATA_W = 32;

    localparam logic [OP_W-1:0] OP_FMV  = 6'b000110;
    localparam logic [OP_W-1:0] OP_FORI = 6'b111101;
    localparam logic [OP_W-1:0] OP_SET  = 6'b111110;
    localparam logic [OP_W-1:0] OP_GET  = 6'b111111;
    localparam logic [OP_W-1:0] OP_FNEG = 6'b010000;
    localparam logic [OP_W-1:0] OP_FABS = 6'b000101;
    localparam logic [OP_W-1:0] OP_FADD = 6'b000000;
    localparam logic [OP_W-1:0] OP_FSUB = 6'b000001;
    localparam logic [OP_W-1:0] OP_FMUL = 6'b000010;
    localparam logic [OP_W-1:0] OP_ITOF = 6'b111001;
    localparam logic [OP_W-1:0] OP_FCLT = 6'b100000;
    localparam logic [OP_W-1:0] OP_FCZ  = 6'b101000;
    localparam logic [OP_W-1:0] OP_FTOI = 6'b111000;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, RESP} state_e;
    typedef enum logic [1:0] {CLS_SIMPLE, CLS_LONG, CLS_FLAG, CLS_ILLEGAL} cls_e;

    function automatic cls_e op_class(input logic [OP_W-1:0] op);
        case (op)
            OP_FMV, OP_FORI, OP_SET, OP_GET:                   return CLS_SIMPLE;
            OP_FNEG, OP_FABS, OP_FADD, OP_FSUB, OP_FMUL, OP_ITOF: return CLS_LONG;
            OP_FCLT, OP_FCZ, OP_FTOI:                          return CLS_FLAG;
            default:                                           return CLS_ILLEGAL;
        endcase
    endfunction

    state_e             state_q, state_d;
    logic [REG_W-1:0]   x1_q, x1_d, x2_q, x2_d, y_q, y_d;
    logic [OP_W-1:0]    op_q, op_d;
    logic [DATA_W-1:0]  in_data_q, in_data_d;
    logic               fpu_ready_q, fpu_ready_d;
    logic               resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0]  resp_data_q, resp_data_d;
    logic               resp_cond_q, resp_cond_d;
    logic               resp_err_q, resp_err_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    cls_e req_cls;
    cls_e cur_cls;
    assign req_cls = op_class(bus.req_op);
    assign cur_cls = op_class(op_q);

    always_comb begin
        state_d      = state_q;
        x1_d         = x1_q;
        x2_d         = x2_q;
        y_d          = y_q;
        op_d         = op_q;
        in_data_d    = in_data_q;
        fpu_ready_d  = fpu_ready_q;
        resp_valid_d = resp_valid_q;
        resp_data_d  = resp_data_q;
        resp_cond_d  = resp_cond_q;
        resp_err_d   = resp_err_q;
        cnt_d        = cnt_q;

        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    resp_data_d = '0;
                    resp_cond_d = 1'b0;
                    if (req_cls == CLS_ILLEGAL) begin
                        resp_err_d   = 1'b1;
                        resp_valid_d = 1'b1;
                        state_d      = RESP;
                    end else begin
                        x1_d        = bus.req_x1;
                        x2_d        = bus.req_x2;
                        y_d         = bus.req_y;
                        op_d        = bus.req_op;
                        in_data_d   = bus.req_data;
                        resp_err_d  = 1'b0;
                        fpu_ready_d = 1'b1;
                        cnt_d       = '0;
                        state_d     = ISSUE;
                    end
                end
            end
            ISSUE: begin
                cnt_d = cnt_q + CNT_W'(1);
                // A completing handshake takes priority over an expiring timeout.
                if (bus.fpu_valid) begin
                    fpu_ready_d = 1'b0;
                    case (cur_cls)
                        CLS_SIMPLE: begin
                            resp_data_d  = (op_q == OP_GET) ? bus.fpu_out_data : '0;
                            resp_valid_d = 1'b1;
                            state_d      = RESP;
                        end
                        CLS_FLAG: begin
                            resp_data_d = (op_q == OP_FTOI) ? bus.fpu_out_data : '0;
                            state_d     = DRAIN;
                        end
                        default: begin
                            resp_data_d  = '0;
                            resp_valid_d = 1'b1;
                            state_d      = RESP;
                        end
                    endcase
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    fpu_ready_d  = 1'b0;
                    resp_err_d   = 1'b1;
                    resp_valid_d = 1'b1;
                    state_d      = RESP;
                end
            end
            DRAIN: begin
                // Opcode and destination stay put so the FPU write cycle is a no-op.
                resp_cond_d  = (op_q == OP_FTOI) ? 1'b0 : bus.fpu_cond;
                resp_valid_d = 1'b1;
                state_d      = RESP;
            end
            RESP: begin
                if (bus.resp_ready) begin
                    resp_valid_d = 1'b0;
                    resp_err_d   = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= IDLE;
            x1_q         <= '0;
            x2_q         <= '0;
            y_q          <= '0;
            op_q         <= '0;
            in_data_q    <= '0;
            fpu_ready_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            resp_cond_q  <= 1'b0;
            resp_err_q   <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            x1_q         <= x1_d;
            x2_q         <= x2_d;
            y_q          <= y_d;
            op_q         <= op_d;
            in_data_q    <= in_data_d;
            fpu_ready_q  <= fpu_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_cond_q  <= resp_cond_d;
            resp_err_q   <= resp_err_d;
            cnt_q        <= cnt_d;
        end
    end

    assign bus.req_ready     = (state_q == IDLE);
    assign bus.busy          = (state_q != IDLE);
    assign bus.fpu_x1        = x1_q;
    assign bus.fpu_x2        = x2_q;
    assign bus.fpu_y         = y_q;
    assign bus.fpu_operation = op_q;
    assign bus.fpu_in_data   = in_data_q;
    assign bus.fpu_ready     = fpu_ready_q;
    assign bus.resp_valid    = resp_valid_q;
    assign bus.resp_data     = resp_data_q;
    assign bus.resp_cond     = resp_cond_q;
    assign bus.resp_err      = resp_err_q;
endmodule

// File: tb/tb_fpu_issuer.sv
// Bench for fpu_issuer: timing-accurate FPU model plus an architectural
// register-file reference, driven by directed and random instructions.
module tb_fpu_issuer;
    localparam int unsigned TO  = 4;
    localparam int unsigned CW  = 3;

    localparam logic [5:0] FMV  = 6'b000110, FORI = 6'b111101, SET  = 6'b111110, GET  = 6'b111111;
    localparam logic [5:0] FNEG = 6'b010000, FABS = 6'b000101, FADD = 6'b000000, FSUB = 6'b000001;
    localparam logic [5:0] FMUL = 6'b000010, ITOF = 6'b111001;
    localparam logic [5:0] FCLT = 6'b100000, FCZ  = 6'b101000, FTOI = 6'b111000;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    fpu_issuer_if bus();

    fpu_issuer #(.TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // 0 simple, 1 long, 2 flag, 3 illegal
    function automatic int op_kind(input logic [5:0] op);
        case (op)
            FMV, FORI, SET, GET:                    return 0;
            FNEG, FABS, FADD, FSUB, FMUL, ITOF:     return 1;
            FCLT, FCZ, FTOI:                        return 2;
            default:                                return 3;
        endcase
    endfunction

    function automatic real f2r(input logic [31:0] f);
        logic [63:0] b;
        if (f[30:23] == 8'd0) return 0.0;
        b = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0};
        return $bitstoreal(b);
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] b;
        int e;
        if (r == 0.0) return 32'd0;
        b = $realtobits(r);
        e = int'(b[62:52]) - 896;
        if (e <= 0)   return {b[63], 31'd0};
        if (e >= 255) return {b[63], 8'hFF, 23'd0};
        return {b[63], 8'(e), b[51:29]};
    endfunction

    // Arithmetic meaning of each opcode: {cond, result}.
    function automatic logic [32:0] alu(input logic [5:0] op, input logic [31:0] a, b, d);
        real ra, rb;
        ra = f2r(a);
        rb = f2r(b);
        case (op)
            FADD: return {1'b0, r2f(ra + rb)};
            FSUB: return {1'b0, r2f(ra - rb)};
            FMUL: return {1'b0, r2f(ra * rb)};
            FNEG: return {1'b0, ~a[31], a[30:0]};
            FABS: return {2'b00, a[30:0]};
            ITOF: return {1'b0, r2f($itor($signed(d)))};
            FCLT: return {ra < rb, 32'd0};
            FCZ:  return {ra == 0.0, 32'd0};
            FTOI: begin
                if (ra > 1.0e9 || ra < -1.0e9) return {1'b0, 32'h7FFFFFFF};
                return {1'b0, 32'($rtoi(ra))};
            end
            FMV:  return {1'b0, a};
            FORI: return {1'b0, a | d};
            SET:  return {1'b0, d};
            GET:  return {1'b0, a};
            default: return 33'd0;
        endcase
    endfunction

    // ---------------- FPU timing model ----------------
    typedef enum int {F_WAIT, F_BUSY, F_WRITE} fst_e;
    fst_e        fst;
    int          fcnt;
    logic [31:0] frf [32];
    logic [31:0] fres_q;
    logic        fcond_pend_q, fcond_q;
    int          fpu_lat = 0;
    bit          fpu_hang = 1'b0;

    always_comb begin
        bus.fpu_valid    = 1'b0;
        bus.fpu_out_data = fres_q;
        bus.fpu_cond     = fcond_q;
        if (!fpu_hang) begin
            if (fst == F_WAIT && bus.fpu_ready && op_kind(bus.fpu_operation) == 0) begin
                bus.fpu_valid    = 1'b1;
                bus.fpu_out_data = (bus.fpu_operation == GET) ? frf[bus.fpu_x1] : 32'd0;
            end else if (fst == F_WRITE) begin
                bus.fpu_valid = 1'b1;
            end
        end
    end

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fst          <= F_WAIT;
            fcnt         <= 0;
            fres_q       <= 32'd0;
            fcond_pend_q <= 1'b0;
            fcond_q      <= 1'b0;
            for (int i = 0; i < 32; i++) frf[i] <= 32'd0;
        end else begin
            case (fst)
                F_WAIT: if (bus.fpu_ready && !fpu_hang) begin
                    if (op_kind(bus.fpu_operation) == 0) begin
                        if (bus.fpu_operation != GET)
                            frf[bus.fpu_y] <= alu(bus.fpu_operation, frf[bus.fpu_x1],
                                                  frf[bus.fpu_x2], bus.fpu_in_data);
                    end else begin
                        {fcond_pend_q, fres_q} <= alu(bus.fpu_operation, frf[bus.fpu_x1],
                                                      frf[bus.fpu_x2], bus.fpu_in_data);
                        fcnt <= fpu_lat;
                        fst  <= (fpu_lat == 0) ? F_WRITE : F_BUSY;
                    end
                end
                F_BUSY: begin
                    fcnt <= fcnt - 1;
                    if (fcnt == 1) fst <= F_WRITE;
                end
                default: if (bus.fpu_ready) begin
                    if (op_kind(bus.fpu_operation) == 1) frf[bus.fpu_y] <= fres_q;
                    else fcond_q <= fcond_pend_q;
                    fst <= F_WAIT;
                end
            endcase
        end
    end

    // ---------------- architectural reference + driver ----------------
    logic [31:0] ref_rf [32];

    task automatic do_op(input logic [5:0] op, input logic [4:0] x1, x2, y,
                         input logic [31:0] d, input int lat, input bit hang, input int hold);
        logic [32:0] r;
        logic [31:0] e_data, s_data;
        logic        e_cond, e_err, s_cond, s_err;
        int          kind, e_lat, e_rdy, e_drain, seen, rdy_cnt, drain_cnt;
        bit          fields_ok, stable;
        kind = op_kind(op);
        r = alu(op, ref_rf[x1], ref_rf[x2], d);
        e_data = 32'd0; e_cond = 1'b0; e_err = 1'b0;
        if (kind == 3) begin
            e_err = 1'b1; e_lat = 1; e_rdy = 0;
        end else if (hang) begin
            e_err = 1'b1; e_lat = TO + 1; e_rdy = TO;
        end else begin
            if (op == GET || op == FTOI) e_data = r[31:0];
            if (op == FCLT || op == FCZ) e_cond = r[32];
            e_lat = (kind == 0) ? 2 : (kind == 1) ? lat + 3 : lat + 4;
            e_rdy = (kind == 0) ? 1 : lat + 2;
            if (kind == 1 || (kind == 0 && op != GET)) ref_rf[y] = r[31:0];
        end
        e_drain = (kind == 2 && !hang) ? 1 : 0;

        fpu_lat  = lat;
        fpu_hang = hang;
        @(negedge clk);
        check("req_ready_idle", 32'(bus.req_ready), 32'd1);
        bus.req_op = op; bus.req_x1 = x1; bus.req_x2 = x2; bus.req_y = y; bus.req_data = d;
        bus.req_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.req_op = 6'($urandom); bus.req_x1 = 5'($urandom); bus.req_data = $urandom;

        seen = 0; rdy_cnt = 0; drain_cnt = 0; fields_ok = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (bus.fpu_ready) begin
                rdy_cnt++;
                if (bus.fpu_operation != op || bus.fpu_x1 != x1 || bus.fpu_x2 != x2 ||
                    bus.fpu_y != y || bus.fpu_in_data != d) fields_ok = 1'b0;
            end
            if (bus.busy && !bus.fpu_ready && !bus.resp_valid) begin
                drain_cnt++;
                if (bus.fpu_operation != op || bus.fpu_y != y) fields_ok = 1'b0;
            end
            if (bus.resp_valid) begin
                seen = c;
                break;
            end
        end
        check("latency", 32'(seen), 32'(e_lat));
        check("fpu_ready_cycles", 32'(rdy_cnt), 32'(e_rdy));
        check("drain_cycles", 32'(drain_cnt), 32'(e_drain));
        if (kind != 3) check("fpu_fields_held", 32'(fields_ok), 32'd1);
        check("resp_data", bus.resp_data, e_data);
        check("resp_cond", 32'(bus.resp_cond), 32'(e_cond));
        check("resp_err", 32'(bus.resp_err), 32'(e_err));

        s_data = bus.resp_data; s_cond = bus.resp_cond; s_err = bus.resp_err;
        stable = 1'b1;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            if (bus.resp_valid !== 1'b1 || bus.resp_data !== s_data || bus.resp_cond !== s_cond ||
                bus.resp_err !== s_err || bus.req_ready !== 1'b0 || bus.fpu_ready !== 1'b0)
                stable = 1'b0;
        end
        if (hold > 0) check("resp_hold_stable", 32'(stable), 32'd1);
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.resp_ready = 1'b0;
        @(negedge clk);
        check("resp_valid_drop", 32'(bus.resp_valid), 32'd0);
        check("resp_err_clear", 32'(bus.resp_err), 32'd0);
        check("req_ready_after", 32'(bus.req_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [5:0] legal [13];
        logic [5:0] op;
        logic [31:0] d;
        legal = '{FMV, FORI, SET, GET, FNEG, FABS, FADD, FSUB, FMUL, ITOF, FCLT, FCZ, FTOI};
        for (int i = 0; i < 32; i++) ref_rf[i] = 32'd0;
        bus.req_valid = 1'b0; bus.req_op = 6'd0; bus.req_x1 = 5'd0; bus.req_x2 = 5'd0;
        bus.req_y = 5'd0; bus.req_data = 32'd0; bus.resp_ready = 1'b0;

        #12;
        check("rst_fpu_ready", 32'(bus.fpu_ready), 32'd0);
        check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rst_resp_data", bus.resp_data, 32'd0);
        check("rst_resp_flags", {30'd0, bus.resp_cond, bus.resp_err}, 32'd0);
        check("rst_fpu_fields", {bus.fpu_operation, bus.fpu_x1, bus.fpu_x2, bus.fpu_y, 11'd0}, 32'd0);
        check("rst_fpu_in_data", bus.fpu_in_data, 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_req_ready", 32'(bus.req_ready), 32'd1);
        @(negedge clk);
        rstn = 1'b1;

        do_op(SET, 5'd0, 5'd0, 5'd3, 32'h3F800000, 0, 1'b0, 0);
        do_op(GET, 5'd3, 5'd0, 5'd0, 32'd0, 0, 1'b0, 0);
        check("get_value", bus.resp_data, 32'h3F800000);
        do_op(SET, 5'd0, 5'd0, 5'd1, 32'h40000000, 0, 1'b0, 0);
        do_op(SET, 5'd0, 5'd0, 5'd2, 32'h3F800000, 0, 1'b0, 0);
        do_op(FADD, 5'd1, 5'd2, 5'd4, 32'd0, 1, 1'b0, 0);
        do_op(GET, 5'd4, 5'd0, 5'd0, 32'd0, 0, 1'b0, 0);
        check("fadd_value", bus.resp_data, 32'h40400000);
        do_op(FCLT, 5'd2, 5'd1, 5'd0, 32'd0, 0, 1'b0, 0);
        do_op(FCLT, 5'd1, 5'd2, 5'd0, 32'd0, 1, 1'b0, 0);
        do_op(SET, 5'd0, 5'd0, 5'd1, 32'h40400000, 0, 1'b0, 0);
        do_op(FTOI, 5'd1, 5'd0, 5'd0, 32'd0, 2, 1'b0, 0);
        do_op(GET, 5'd3, 5'd0, 5'd0, 32'd0, 0, 1'b0, 0);
        do_op(6'b010101, 5'd1, 5'd2, 5'd3, 32'd0, 0, 1'b0, 0);
        do_op(FADD, 5'd1, 5'd2, 5'd5, 32'd0, 0, 1'b1, 0);
        do_op(FADD, 5'd1, 5'd2, 5'd5, 32'd0, 2, 1'b0, 0);
        do_op(GET, 5'd4, 5'd0, 5'd0, 32'd0, 0, 1'b0, 5);

        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(9) == 0) begin
                op = 6'($urandom);
                while (op_kind(op) != 3) op = 6'($urandom);
            end else begin
                op = legal[$urandom_range(12)];
            end
            d = $urandom;
            if (op == SET) d = r2f($itor($signed(32'($urandom_range(24)) - 32'd8)));
            if (op == ITOF) d = 32'($urandom_range(40)) - 32'd20;
            if (op == FORI) d = 32'($urandom_range(255));
            do_op(op, 5'($urandom_range(7)), 5'($urandom_range(7)), 5'($urandom_range(7)), d,
                  $urandom_range(2), ($urandom_range(19) == 0), $urandom_range(3));
        end

        // Asynchronous reset in the middle of an ISSUE phase.
        fpu_hang = 1'b1;
        @(negedge clk);
        bus.req_op = FADD; bus.req_x1 = 5'd1; bus.req_x2 = 5'd2; bus.req_y = 5'd6;
        bus.req_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(posedge clk);
        #3;
        check("pre_rst_fpu_ready", 32'(bus.fpu_ready), 32'd1);
        rstn = 1'b0;
        #1;
        check("mid_rst_fpu_ready", 32'(bus.fpu_ready), 32'd0);
        check("mid_rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        check("mid_rst_req_ready", 32'(bus.req_ready), 32'd1);
        @(negedge clk);
        rstn = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_no_resp", 32'(bus.resp_valid), 32'd0);
        check("post_rst_idle", 32'(bus.busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/fpu_issuer.md
Name: fpu_issuer

Overview:
- Core-side initiator for the FPU command interface; drives the FPU's x1/x2/y/operation/in_data/ready and consumes valid/cond/out_data.
- Accepts one decoded FP instruction at a time from the core via a valid/ready request channel.
- Sequences the FPU handshake, including the post-completion drain cycle some FPU ops require.
- Returns exactly one response per request (data/cond/error) on a valid/ready response channel.

Parameters:
TIMEOUT, 255, max ISSUE cycles without fpu_valid before abort
CNT_W, 8, timeout counter width; must satisfy 2^CNT_W > TIMEOUT

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
req_valid  in  1  core presents instruction
req_ready  out  1  issuer accepts instruction
req_op  in  6  FPU opcode
req_x1  in  5  source register 1
req_x2  in  5  source register 2
req_y  in  5  destination register
req_data  in  32  immediate/integer operand (SET, FORI, ITOF)
resp_valid  out  1  response available
resp_ready  in  1  core takes response
resp_data  out  32  GET/FTOI result, else 0
resp_cond  out  1  FCLT/FCZ result, else 0
resp_err  out  1  illegal opcode or timeout
busy  out  1  state != IDLE
fpu_x1, fpu_x2, fpu_y  out  5 each  to FPU
fpu_operation  out  6  to FPU
fpu_in_data  out  32  to FPU
fpu_ready  out  1  to FPU
fpu_valid  in  1  from FPU
fpu_cond  in  1  from FPU
fpu_out_data  in  32  from FPU

Behaviour:
- Clock clk; reset rstn is asynchronous, active-low. All outputs and registers are registered except req_ready and busy, which decode state.
- Reset: state IDLE; fpu_ready=0; all fpu_* fields=0; resp_valid=0; resp_data=0; resp_cond=0; resp_err=0; counter=0. Reset mid-operation drops fpu_ready immediately and abandons any response. The FPU is reset by the same rstn.
- Opcode classes:
  - SIMPLE: FMV 000110, FORI 111101, SET 111110, GET 111111.
  - LONG: FNEG 010000, FABS 000101, FADD 000000, FSUB 000001, FMUL 000010, ITOF 111001.
  - FLAG: FCLT 100000, FCZ 101000, FTOI 111000.
  - Any other opcode is ILLEGAL.
- req_ready=1 only in IDLE.
- States: IDLE, ISSUE, DRAIN, RESP.
- IDLE, on req_valid:
  - ILLEGAL: RESP with resp_err=1, data=0, cond=0; fpu_ready stays 0.
  - Otherwise: latch fields into fpu_* outputs, set fpu_ready=1, clear counter, go to ISSUE.
- ISSUE:
  - fpu_* outputs held stable; counter increments each cycle.
  - Handshake completes at a rising edge with fpu_ready && fpu_valid. At that edge: fpu_ready<=0.
    - SIMPLE: resp_data<=(GET ? fpu_out_data : 0); go to RESP.
    - LONG: resp_data<=0; go to RESP.
    - FLAG: resp_data<=(FTOI ? fpu_out_data : 0); go to DRAIN.
  - Timeout: counter==TIMEOUT-1 without fpu_valid gives fpu_ready<=0, resp_err<=1, go to RESP. If fpu_valid coincides with the timeout cycle, the handshake wins and resp_err=0.
- DRAIN (exactly 1 cycle, FLAG only):
  - fpu_ready=0; fpu_operation and fpu_y held, so the FPU's write cycle sees an unchanged FLAG opcode and writes nothing.
  - End of cycle: resp_cond<=fpu_cond for FCLT/FCZ, 0 for FTOI; go to RESP.
- RESP:
  - resp_valid=1; data/cond/err held stable until resp_ready.
  - On resp_valid && resp_ready: resp_valid<=0; resp_err<=0; go to IDLE.
  - A new request is accepted no earlier than the cycle after the response handshake.
- fpu_* fields keep their last value in IDLE/RESP; fpu_ready is 1 only in ISSUE.
- Minimum latency, request accept to resp_valid:
  - SIMPLE: 2 cycles (FPU valid is combinational in its wait state).
  - LONG: 1 + FPU latency.
  - FLAG: 1 + FPU latency + 1 DRAIN cycle.
  - ILLEGAL: 1 cycle.
- Back-to-back LONG ops are safe: the FPU asserts valid in its write state and returns to wait on the next edge.

Test Plan:
- SET y=3 data=0x3F800000, then GET x1=3 -> each resp_valid 2 cycles after accept; GET resp_data=0x3F800000, resp_err=0; fpu_ready high exactly one cycle per op.
- SET r1=0x40000000, SET r2=0x3F800000, FADD x1=1 x2=2 y=4, GET x1=4 -> resp_data=0x40400000; fpu_ready held until fpu_valid, then low.
- FCLT x1=2 (1.0) x2=1 (2.0) -> DRAIN entered for one cycle with fpu_operation=100000 held, fpu_ready=0; resp_cond=1; then swapped operands give resp_cond=0.
- FTOI on r1=0x40400000 (3.0) -> resp_data=3; the following GET of unrelated registers is unchanged (no spurious write).
- req_op=6'b010101 -> resp_err=1 after 1 cycle, fpu_ready never asserted; with fpu_valid forced 0 and TIMEOUT=4, FADD -> resp_err=1 after 4 ISSUE cycles.
- Hold resp_ready=0 for 5 cycles -> resp fields stable, req_ready=0; assert rstn=0 mid-ISSUE -> fpu_ready and resp_valid drop asynchronously, state IDLE.
